// File: rtl/dpram_fifo_ctrl_if.sv
// Valid/ready stream bundle for dpram_fifo_ctrl: write side (s_*) and read side (m_*).
// slave is the FIFO's view, master is the view of whoever drives and drains it.
interface dpram_fifo_ctrl_if #(
  parameter int DWIDTH = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [DWIDTH-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DWIDTH-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around an external dual-port RAM (A writes, B reads),
// hiding the RAM read latency behind a 2-entry in-order output buffer.
module dpram_fifo_ctrl #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 10,
  parameter     REGOUT = "Y"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  dpram_fifo_ctrl_if.slave  bus,
  output logic              ram_wea,
  output logic [AWIDTH-1:0] ram_addra,
  output logic [DWIDTH-1:0] ram_dataa,
  output logic              ram_web,
  output logic [AWIDTH-1:0] ram_addrb,
  output logic [DWIDTH-1:0] ram_datab,
  input  logic [DWIDTH-1:0] ram_qb,
  output logic [AWIDTH:0]   count,
  output logic              full,
  output logic              empty
);
  localparam logic [AWIDTH:0] DEPTH_C = {1'b1, {AWIDTH{1'b0}}};
  localparam bit              REG_Y   = (REGOUT == "Y");

  logic [AWIDTH-1:0] wr_ptr_r, rd_ptr_r;
  logic [AWIDTH:0]   ram_used_r, count_r, count_n_s;
  logic              inflight_r, s_ready_r, m_valid_r, full_r, empty_r;
  logic [1:0]        buf_occ_r, buf_occ_n_s, occ_after_s;
  logic [DWIDTH-1:0] buf0_r, buf1_r, buf0_n_s, buf1_n_s;
  logic              push_s, pop_s, issue_s, cap_s;

  // clear masks both handshakes so a flush cycle never writes the RAM
  assign push_s      = bus.s_valid && s_ready_r && !clear;
  assign pop_s       = m_valid_r && bus.m_ready && !clear;
  assign occ_after_s = buf_occ_r + {1'b0, inflight_r} - {1'b0, pop_s};
  assign issue_s     = (ram_used_r != {(AWIDTH+1){1'b0}}) && (occ_after_s < 2'd2);
  assign cap_s       = REG_Y ? inflight_r : issue_s;
  assign count_n_s   = count_r + (AWIDTH+1)'(push_s) - (AWIDTH+1)'(pop_s);

  assign ram_wea     = push_s;
  assign ram_addra   = wr_ptr_r;
  assign ram_dataa   = bus.s_data;
  assign ram_web     = 1'b0;
  assign ram_addrb   = rd_ptr_r;
  assign ram_datab   = {DWIDTH{1'b0}};

  assign bus.s_ready = s_ready_r;
  assign bus.m_valid = m_valid_r;
  assign bus.m_data  = buf0_r;
  assign count       = count_r;
  assign full        = full_r;
  assign empty       = empty_r;

  // Output buffer next state: a pop shifts the skid into the head, a capture appends behind
  always_comb begin
    buf_occ_n_s = buf_occ_r;
    buf0_n_s    = buf0_r;
    buf1_n_s    = buf1_r;
    if (pop_s) begin
      buf0_n_s    = buf1_r;
      buf_occ_n_s = buf_occ_r - 2'd1;
    end else begin
      buf0_n_s    = buf0_r;
    end
    if (cap_s) begin
      if (buf_occ_n_s == 2'd0) begin
        buf0_n_s = ram_qb;
      end else begin
        buf1_n_s = ram_qb;
      end
      buf_occ_n_s = buf_occ_n_s + 2'd1;
    end else begin
      buf1_n_s = buf1_n_s;
    end
  end

  // Pointers, RAM occupancy, read pipeline, output buffer and registered status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {AWIDTH{1'b0}};
      rd_ptr_r   <= {AWIDTH{1'b0}};
      ram_used_r <= {(AWIDTH+1){1'b0}};
      count_r    <= {(AWIDTH+1){1'b0}};
      inflight_r <= 1'b0;
      buf_occ_r  <= 2'd0;
      buf0_r     <= {DWIDTH{1'b0}};
      buf1_r     <= {DWIDTH{1'b0}};
      m_valid_r  <= 1'b0;
      s_ready_r  <= 1'b0;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
    end else if (clear) begin
      wr_ptr_r   <= {AWIDTH{1'b0}};
      rd_ptr_r   <= {AWIDTH{1'b0}};
      ram_used_r <= {(AWIDTH+1){1'b0}};
      count_r    <= {(AWIDTH+1){1'b0}};
      inflight_r <= 1'b0;
      buf_occ_r  <= 2'd0;
      buf0_r     <= {DWIDTH{1'b0}};
      buf1_r     <= {DWIDTH{1'b0}};
      m_valid_r  <= 1'b0;
      s_ready_r  <= 1'b1;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
    end else begin
      wr_ptr_r   <= wr_ptr_r + AWIDTH'(push_s);
      rd_ptr_r   <= rd_ptr_r + AWIDTH'(issue_s);
      ram_used_r <= ram_used_r + (AWIDTH+1)'(push_s) - (AWIDTH+1)'(issue_s);
      count_r    <= count_n_s;
      // with a combinational RAM the data is taken on the issuing edge, so nothing is in flight
      inflight_r <= REG_Y ? issue_s : 1'b0;
      buf_occ_r  <= buf_occ_n_s;
      buf0_r     <= buf0_n_s;
      buf1_r     <= buf1_n_s;
      m_valid_r  <= (buf_occ_n_s != 2'd0);
      s_ready_r  <= (count_n_s != DEPTH_C);
      full_r     <= (count_n_s == DEPTH_C);
      empty_r    <= (count_n_s == {(AWIDTH+1){1'b0}});
    end
  end
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: REGOUT="Y" and REGOUT="N" instances on behavioural RAMs, driven
// in lockstep and scored against a queue model, a vector table and directed corner sequences.
module tb_dpram_fifo_ctrl;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  localparam int O_CNT = 0, O_FULL = 1, O_EMPTY = 2, O_SRDY = 3, O_MV = 4, O_MD = 5,
                 O_WEA = 6, O_WEB = 7, O_DATB = 8;

  logic clk, rst_n, clear;
  dpram_fifo_ctrl_if #(.DWIDTH(DW)) bus_y ();
  dpram_fifo_ctrl_if #(.DWIDTH(DW)) bus_n ();

  logic          wea_y, web_y, full_y, empty_y, wea_n, web_n, full_n, empty_n;
  logic [AW-1:0] addra_y, addrb_y, addra_n, addrb_n;
  logic [DW-1:0] dataa_y, datab_y, qb_y, dataa_n, datab_n, qb_n;
  logic [AW:0]   count_y, count_n;
  logic [DW-1:0] ram_y [DEPTH];
  logic [DW-1:0] ram_n [DEPTH];

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] mq [2][64];
  int mh [2];
  int mt [2];
  int pushes [2];
  int pops [2];

  dpram_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .REGOUT("Y")) u_dut_y (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_y),
    .ram_wea(wea_y), .ram_addra(addra_y), .ram_dataa(dataa_y),
    .ram_web(web_y), .ram_addrb(addrb_y), .ram_datab(datab_y), .ram_qb(qb_y),
    .count(count_y), .full(full_y), .empty(empty_y)
  );

  dpram_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .REGOUT("N")) u_dut_n (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_n),
    .ram_wea(wea_n), .ram_addra(addra_n), .ram_dataa(dataa_n),
    .ram_web(web_n), .ram_addrb(addrb_n), .ram_datab(datab_n), .ram_qb(qb_n),
    .count(count_n), .full(full_n), .empty(empty_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-output RAM and combinational-read RAM
  always @(posedge clk) begin
    if (wea_y) ram_y[addra_y] <= dataa_y;
    qb_y <= ram_y[addrb_y];
  end
  always @(posedge clk) begin
    if (wea_n) ram_n[addra_n] <= dataa_n;
  end
  assign qb_n = ram_n[addrb_n];

  function automatic logic [31:0] obs(input int d, input int f);
    logic [31:0] v;
    v = 32'd0;
    case (f)
      O_CNT:   v = (d == 0) ? 32'(count_y)       : 32'(count_n);
      O_FULL:  v = (d == 0) ? 32'(full_y)        : 32'(full_n);
      O_EMPTY: v = (d == 0) ? 32'(empty_y)       : 32'(empty_n);
      O_SRDY:  v = (d == 0) ? 32'(bus_y.s_ready) : 32'(bus_n.s_ready);
      O_MV:    v = (d == 0) ? 32'(bus_y.m_valid) : 32'(bus_n.m_valid);
      O_MD:    v = (d == 0) ? 32'(bus_y.m_data)  : 32'(bus_n.m_data);
      O_WEA:   v = (d == 0) ? 32'(wea_y)         : 32'(wea_n);
      O_WEB:   v = (d == 0) ? 32'(web_y)         : 32'(web_n);
      O_DATB:  v = (d == 0) ? 32'(datab_y)       : 32'(datab_n);
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: actual=%0h required=%0h", nm, d, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, score handshakes 1 time unit later, check state at next fall
  task automatic step(input logic sv0, input logic sv1, input logic mr0, input logic mr1,
                      input logic clr, input logic [15:0] din);
    logic sv [2];
    logic mr [2];
    bit   psh, pp;
    int   sz;
    sv[0] = sv0; sv[1] = sv1; mr[0] = mr0; mr[1] = mr1;
    bus_y.s_valid = sv0; bus_n.s_valid = sv1;
    bus_y.m_ready = mr0; bus_n.m_ready = mr1;
    bus_y.s_data  = din; bus_n.s_data  = din;
    clear = clr;
    #1;
    for (int d = 0; d < 2; d++) begin
      psh = sv[d] && (obs(d, O_SRDY) != 32'd0) && !clr;
      pp  = mr[d] && (obs(d, O_MV) != 32'd0) && !clr;
      chk("ram_wea", d, obs(d, O_WEA), 32'(psh));
      if (obs(d, O_MV) != 32'd0) begin
        if (mt[d] == mh[d]) chk("mvalid_model_empty", d, obs(d, O_MV), 32'd0);
        else chk("head_data", d, obs(d, O_MD), 32'(mq[d][mh[d] % 64]));
      end
      if (pp && mt[d] != mh[d]) mh[d]++;
      if (pp) pops[d]++;
      if (psh) begin
        mq[d][mt[d] % 64] = din;
        mt[d]++;
        pushes[d]++;
      end
      if (clr) mh[d] = mt[d];
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sz = mt[d] - mh[d];
      chk("count",   d, obs(d, O_CNT),   32'(sz));
      chk("empty",   d, obs(d, O_EMPTY), 32'(sz == 0));
      chk("full",    d, obs(d, O_FULL),  32'(sz == DEPTH));
      chk("s_ready", d, obs(d, O_SRDY),  32'(sz != DEPTH));
      if (sz == 0) chk("mvalid_when_empty", d, obs(d, O_MV), 32'd0);
    end
  endtask

  task automatic rst_check(input string nm);
    for (int d = 0; d < 2; d++) begin
      chk({nm, "_s_ready"}, d, obs(d, O_SRDY), 32'd0);
      chk({nm, "_m_valid"}, d, obs(d, O_MV), 32'd0);
      chk({nm, "_m_data"},  d, obs(d, O_MD), 32'd0);
      chk({nm, "_count"},   d, obs(d, O_CNT), 32'd0);
      chk({nm, "_empty"},   d, obs(d, O_EMPTY), 32'd1);
      chk({nm, "_full"},    d, obs(d, O_FULL), 32'd0);
      chk({nm, "_wea"},     d, obs(d, O_WEA), 32'd0);
      chk({nm, "_web"},     d, obs(d, O_WEB), 32'd0);
      chk({nm, "_datab"},   d, obs(d, O_DATB), 32'd0);
    end
  endtask

  // Assert reset between edges, check it took effect at once, release, then see s_ready rise
  task automatic do_reset(input string nm);
    bus_y.s_valid = 1'b0; bus_n.s_valid = 1'b0;
    bus_y.m_ready = 1'b0; bus_n.m_ready = 1'b0;
    clear = 1'b0;
    #3 rst_n = 1'b0;
    #1 rst_check(nm);
    for (int d = 0; d < 2; d++) mh[d] = mt[d];
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) chk({nm, "_srdy_before_edge"}, d, obs(d, O_SRDY), 32'd0);
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk({nm, "_srdy_after_edge"}, d, obs(d, O_SRDY), 32'd1);
  endtask

  typedef struct {
    logic        sv;
    logic        mr;
    logic [15:0] din;
    logic [3:0]  e_cnt;
    logic        e_full;
    logic        e_empty;
    logic        e_srdy;
    logic        chk_m;
    logic        e_mv;
    logic [15:0] e_md;
  } vec_t;

  vec_t tbl [17];
  int   b_push [2];
  int   b_pop [2];
  logic r_sv0, r_sv1, r_mr0, r_mr1;

  initial begin
    // Fill 1..8 with the read side stalled, try a push while full, then drain one per cycle
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 1'b0, 16'(i + 1), 4'(i + 1), (i == 7), 1'b0, (i != 7), 1'b0, 1'b0, 16'h0000};
    tbl[8] = '{1'b1, 1'b0, 16'h00FF, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0001};
    for (int j = 0; j < 8; j++)
      tbl[9 + j] = '{1'b0, 1'b1, 16'h0000, 4'(7 - j), 1'b0, (j == 7), 1'b1, 1'b1, (j != 7), 16'(j + 2)};

    for (int d = 0; d < 2; d++) begin
      mh[d] = 0; mt[d] = 0; pushes[d] = 0; pops[d] = 0;
    end
    rst_n = 1'b0;
    clear = 1'b0;
    bus_y.s_valid = 1'b0; bus_n.s_valid = 1'b0;
    bus_y.m_ready = 1'b0; bus_n.m_ready = 1'b0;
    bus_y.s_data = 16'h0000; bus_n.s_data = 16'h0000;
    @(negedge clk);
    do_reset("por");

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].sv, tbl[i].sv, tbl[i].mr, tbl[i].mr, 1'b0, tbl[i].din);
      for (int d = 0; d < 2; d++) begin
        chk("tbl_count",   d, obs(d, O_CNT),   32'(tbl[i].e_cnt));
        chk("tbl_full",    d, obs(d, O_FULL),  32'(tbl[i].e_full));
        chk("tbl_empty",   d, obs(d, O_EMPTY), 32'(tbl[i].e_empty));
        chk("tbl_s_ready", d, obs(d, O_SRDY),  32'(tbl[i].e_srdy));
        if (tbl[i].chk_m) begin
          chk("tbl_m_valid", d, obs(d, O_MV), 32'(tbl[i].e_mv));
          if (tbl[i].e_mv) chk("tbl_m_data", d, obs(d, O_MD), 32'(tbl[i].e_md));
        end
      end
    end

    // Streaming: 100 words, both sides always ready; latency 3 edges (Y) / 2 edges (N) after first push edge
    for (int d = 0; d < 2; d++) b_pop[d] = pops[d];
    for (int k = 0; k < 100; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'(16'h1000 + k));
      if (k == 0) begin
        chk("lat_y_edge1", 0, obs(0, O_MV), 32'd0);
        chk("lat_n_edge1", 1, obs(1, O_MV), 32'd0);
      end
      if (k == 1) begin
        chk("lat_y_edge2", 0, obs(0, O_MV), 32'd0);
        chk("lat_n_edge2", 1, obs(1, O_MV), 32'd1);
      end
      if (k == 2) chk("lat_y_edge3", 0, obs(0, O_MV), 32'd1);
    end
    chk("stream_pops_y", 0, 32'(pops[0] - b_pop[0]), 32'd97);
    chk("stream_pops_n", 1, 32'(pops[1] - b_pop[1]), 32'd98);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    for (int d = 0; d < 2; d++) chk("stream_total", d, 32'(pops[d] - b_pop[d]), 32'd100);

    // Random backpressure: 2000 words per instance, 50% valid / ready
    for (int d = 0; d < 2; d++) begin
      b_push[d] = pushes[d];
      b_pop[d]  = pops[d];
    end
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (pops[0] - b_pop[0] >= 2000 && pops[1] - b_pop[1] >= 2000) break;
      r_sv0 = ($urandom_range(0, 1) == 1) && (pushes[0] - b_push[0] < 2000);
      r_sv1 = ($urandom_range(0, 1) == 1) && (pushes[1] - b_push[1] < 2000);
      r_mr0 = ($urandom_range(0, 1) == 1);
      r_mr1 = ($urandom_range(0, 1) == 1);
      step(r_sv0, r_sv1, r_mr0, r_mr1, 1'b0, 16'($urandom));
    end
    for (int d = 0; d < 2; d++) chk("rand_words", d, 32'(pops[d] - b_pop[d]), 32'd2000);

    // Wrap-around holding 7..8 entries, including pop-while-full with s_valid asserted
    for (int w = 0; w < 8; w++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'(w));
    for (int w = 8; w < 20; w++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'(w));
      for (int d = 0; d < 2; d++) begin
        chk("fullpop_count", d, obs(d, O_CNT), 32'd7);
        chk("fullpop_s_ready", d, obs(d, O_SRDY), 32'd1);
      end
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'(w));
      for (int d = 0; d < 2; d++) chk("refill_full", d, obs(d, O_FULL), 32'd1);
    end
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);

    // Clear with 5 words held and (on the registered-RAM instance) a read in flight
    for (int w = 0; w < 5; w++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h0C00 + w));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0C05);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0C06);
    for (int d = 0; d < 2; d++) begin
      chk("clear_count", d, obs(d, O_CNT), 32'd0);
      chk("clear_m_valid", d, obs(d, O_MV), 32'd0);
    end
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    for (int d = 0; d < 2; d++) b_pop[d] = pops[d];
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'hBEEF);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    for (int d = 0; d < 2; d++) chk("clear_beef_only", d, 32'(pops[d] - b_pop[d]), 32'd1);

    // Asynchronous reset with data held
    for (int w = 0; w < 3; w++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h0D00 + w));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    do_reset("mid_rst");
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    for (int d = 0; d < 2; d++) b_pop[d] = pops[d];
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'hBEEF);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    for (int d = 0; d < 2; d++) chk("rst_beef_only", d, 32'(pops[d] - b_pop[d]), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dpram_fifo_ctrl.md
# dpram_fifo_ctrl

Single-clock FIFO controller that turns a `dpram` instance into a first-word-fall-through stream buffer. It drives port A as the write port and port B as the read port, and it absorbs the RAM read latency with a 2-entry output buffer. It exposes valid/ready streams on both sides and sits directly upstream of the RAM in every buffered datapath. The RAM is instantiated by the parent, with `DWIDTH`, `AWIDTH` and `REGOUT` matching this block.

## Interface
- `DWIDTH`, 16, data width.
- `AWIDTH`, 10, RAM address width; depth `DEPTH = 2**AWIDTH`.
- `REGOUT`, "Y", must equal the attached RAM's setting. "Y" means 1-cycle read latency; "N" means combinational read.

Ports:
- `clk`  in  1  single clock; both RAM clocks tie to it.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `clear`  in  1  synchronous flush.
- `s_valid`  in  1  write stream valid.
- `s_ready`  out  1  write stream ready.
- `s_data`  in  DWIDTH  write data.
- `m_valid`  out  1  read stream valid.
- `m_ready`  in  1  read stream ready.
- `m_data`  out  DWIDTH  read data.
- `ram_wea`  out  1  to RAM `wea`.
- `ram_addra`  out  AWIDTH  to RAM `addra`.
- `ram_dataa`  out  DWIDTH  to RAM `dataa`.
- `ram_web`  out  1  to RAM `web`; constant 0.
- `ram_addrb`  out  AWIDTH  to RAM `addrb`.
- `ram_datab`  out  DWIDTH  to RAM `datab`; constant 0.
- `ram_qb`  in  DWIDTH  from RAM `qb`.
- `count`  out  AWIDTH+1  words held (accepted, not yet popped), 0..DEPTH.
- `full`, `empty`  out  1  `count==DEPTH` / `count==0`.

## Operation
- **Push:** `s_valid && s_ready`. On a push, `ram_wea=1`, `ram_addra=wr_ptr`, `ram_dataa=s_data`, and `wr_ptr` increments. `ram_wea`, `ram_addra` and `ram_dataa` are combinational from the stream inputs.
- **Pop:** `m_valid && m_ready`. The output buffer head is removed.
- **Pointers:** `wr_ptr` and `rd_ptr` are AWIDTH bits and wrap naturally from DEPTH-1 to 0.
- **RAM occupancy:** `ram_used` counts words written to RAM and not yet issued for read. It increments on the edge after the write, so a read never targets a location being written in the same cycle. No read-during-write hazard exists.
- **Read issue:** issued in a cycle when `ram_used>0` and `(buf_occ + inflight − pop) < 2`. On issue, `ram_addrb=rd_ptr`, `rd_ptr` increments, and `ram_used` decrements.
  - REGOUT="Y": `inflight` is set for one cycle, and `ram_qb` is captured into the output buffer on the following edge.
  - REGOUT="N": `ram_qb` is captured on the issuing edge and `inflight` is always 0.
- **Output buffer:** 2-entry (head + skid), in-order. `m_data` is the head. `m_data` holds stable while `m_valid && !m_ready`.
- **Count:** +1 on push, −1 on pop, unchanged on simultaneous push and pop.
- **`s_ready`:** registered, equals `!(next count == DEPTH)`. No push can occur when full, even with a simultaneous pop; `s_ready` rises the cycle after the pop.
- **`clear`:** on the edge it is sampled high:
  - pointers, `ram_used`, `count` and the output buffer go to 0, and `inflight` is discarded;
  - a push or pop in that same cycle is ignored;
  - RAM contents are untouched.
- **Reset** (`rst_n` low, any time, including mid-transfer): all state clears immediately. No residual word appears after release.

## Timing
- **Reset values:** `s_ready=0`, `m_valid=0`, `m_data=0`, `count=0`, `empty=1`, `full=0`, `ram_wea=0`, `ram_web=0`, `ram_datab=0`.
- `s_ready` goes to 1 on the first `clk` edge after `rst_n` deasserts.
- **Latency into an empty FIFO:** a word pushed on edge n gives `m_valid` high after edge n+2 (REGOUT="Y") or edge n+1 (REGOUT="N").
- **Throughput:** one push and one pop per cycle are sustained indefinitely, with no bubbles once the output buffer is primed.
- **Status timing:** `count`, `empty` and `full` are registered and reflect all pushes and pops up to the last edge.
- After `clear` or reset, `m_valid=0` no later than the next edge.

## Test plan
- **Fill and drain:** AWIDTH=3, `m_ready=0`, push 0x0001..0x0008 back-to-back.
  - After the 8th edge: `full=1`, `count=8`, `s_ready=0`.
  - Then with `m_ready=1`, data pops as 0x0001..0x0008 in order on 8 consecutive cycles, then `empty=1`.
- **Streaming:** AWIDTH=3, REGOUT="Y", `s_valid`/`m_ready` held 1, 100 incrementing words.
  - First `m_valid` appears 2 edges after the first push.
  - One word per cycle after that, no gaps, no loss, no duplicates.
- **Random backpressure:** random `s_valid` and `m_ready` (50%) over 2000 words through depth 8, checked against a scoreboard.
  - Order is preserved.
  - `m_data` is stable while stalled.
  - `count` matches the model every cycle.
- **Wrap-around and full-with-pop:** keep the FIFO at 7–8 entries while pushing 0x0000..0x0013.
  - Pointers wrap past 7 with correct data.
  - With `full=1`, a pop gives no push that cycle and `s_ready=1` on the next edge.
- **Clear and reset mid-stream:** with 5 words held and one read in flight, pulse `clear`; later, drop `rst_n` asynchronously with data held.
  - After each: `count=0`, `m_valid=0`.
  - A subsequent push of 0xBEEF is the only word popped.
- **REGOUT="N" variant:** repeat the fill and streaming scenarios.
  - First `m_valid` appears 1 edge after the push.
  - Full throughput holds.
